// File: rtl/alu_mul_seq.sv
// Sequential unsigned 32x32->32 multiplier that borrows the execute-stage ALU.
// Shift-and-add: ADD steps go through the ALU as ADD, multiplicand doubling
// goes through the ALU as SLL by 1; the multiplier shift is done locally.
module alu_mul_seq #(
  parameter int DataSize  = 32,
  parameter int ALUopSize = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DataSize-1:0]  mcand,
  input  logic [DataSize-1:0]  mplier,
  output logic                 busy,
  output logic                 done,
  output logic [DataSize-1:0]  product,
  output logic                 ovf,
  output logic [DataSize-1:0]  alu_src1,
  output logic [DataSize-1:0]  alu_src2,
  output logic [ALUopSize-1:0] alu_op,
  output logic                 alu_en,
  input  logic [DataSize-1:0]  alu_result
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EVAL  = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ALUopSize-1:0] OP_ADD = ALUopSize'(4'b0000);
  localparam logic [ALUopSize-1:0] OP_SLL = ALUopSize'(4'b0100);

  localparam logic [DataSize-1:0] ONE = DataSize'(1);

  logic [2:0]          state_q, state_d;
  logic [DataSize-1:0] acc_q, acc_d;
  logic [DataSize-1:0] mc_q, mc_d;
  logic [DataSize-1:0] mp_q, mp_d;
  logic                ovf_r_q, ovf_r_d;
  logic [DataSize-1:0] product_q, product_d;
  logic                ovf_q, ovf_d;

  // Next-state and datapath update for the shift-and-add sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d   = state_q;
    acc_d     = acc_q;
    mc_d      = mc_q;
    mp_d      = mp_q;
    ovf_r_d   = ovf_r_q;
    product_d = product_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mc_d    = mcand;
          mp_d    = mplier;
          acc_d   = '0;
          ovf_r_d = 1'b0;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (mp_q == '0) begin
          // Results are published on the edge that enters DONE.
          product_d = acc_q;
          ovf_d     = ovf_r_q;
          state_d   = S_DONE;
        end else if (mp_q[0]) begin
          state_d = S_ADD;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_ADD: begin
        acc_d = alu_result;
        // A wrapped sum is smaller than either addend: unsigned carry-out.
        if (alu_result < acc_q) ovf_r_d = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        mc_d = alu_result;
        mp_d = mp_q >> 1;
        // The bit shifted out of mc would still be multiplied by a set bit.
        if (mc_q[DataSize-1] && (mp_q[DataSize-1:1] != '0)) ovf_r_d = 1'b1;
        state_d = S_EVAL;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mc_q      <= '0;
      mp_q      <= '0;
      ovf_r_q   <= 1'b0;
      product_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mc_q      <= mc_d;
      mp_q      <= mp_d;
      ovf_r_q   <= ovf_r_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
    end
  end

  // Moore decode of status and ALU operand/opcode drive from state and registers.
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    alu_en   = 1'b0;
    alu_op   = OP_ADD;
    alu_src1 = '0;
    alu_src2 = '0;
    case (state_q)
      S_ADD: begin
        alu_en   = 1'b1;
        alu_op   = OP_ADD;
        alu_src1 = acc_q;
        alu_src2 = mc_q;
      end
      S_SHIFT: begin
        alu_en   = 1'b1;
        alu_op   = OP_SLL;
        alu_src1 = mc_q;
        alu_src2 = ONE;
      end
      default: begin
        alu_en = 1'b0;
      end
    endcase
  end

  assign product = product_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: models the ALU combinationally and
// compares product/ovf/latency/ALU trace against a spec-level reference.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] mcand, mplier;
  logic        busy, done, ovf, alu_en;
  logic [31:0] product, alu_src1, alu_src2, alu_result;
  logic [3:0]  alu_op;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
  } alu_step_t;

  always #5 clk = ~clk;

  alu_mul_seq #(.DataSize(32), .ALUopSize(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .product(product), .ovf(ovf),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_op(alu_op),
    .alu_en(alu_en), .alu_result(alu_result)
  );

  // Behavioural ALU: ADD and SLL, result valid in the same cycle.
  assign alu_result = !alu_en ? 32'd0 :
                      (alu_op == 4'b0000) ? alu_src1 + alu_src2 :
                      (alu_op == 4'b0100) ? alu_src1 << alu_src2 : 32'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_product"}, product, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_alu"}, {alu_en, alu_op, alu_src1, alu_src2}, 0);
  endtask

  // One full multiply; optionally pokes start while busy and in DONE.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input bit poke);
    logic [63:0] full;
    logic [31:0] exp_p, m_acc, m_mc;
    logic        exp_o;
    int          nb, k, exp_cyc, cyc;
    bit          seen;
    alu_step_t   q[$];
    alu_step_t   e;

    full  = 64'(a) * 64'(b);
    exp_p = full[31:0];
    exp_o = (full[63:32] != 0);
    nb = 0; k = 0;
    for (int i = 0; i < 32; i++) if (b[i]) begin nb = i + 1; k++; end
    exp_cyc = 2 * nb + k + 2;
    m_acc = 0; m_mc = a;
    for (int i = 0; i < nb; i++) begin
      if (b[i]) begin
        q.push_back('{4'b0000, m_acc, m_mc});
        m_acc = m_acc + m_mc;
      end
      q.push_back('{4'b0100, m_mc, 32'd1});
      m_mc = m_mc << 1;
    end

    @(negedge clk);
    start = 1'b1; mcand = a; mplier = b;
    @(negedge clk);
    start = 1'b0; mcand = $urandom; mplier = $urandom;
    cyc = 1; seen = 0;
    while (cyc <= 120 && !seen) begin
      check("busy", busy, 1);
      if (alu_en) begin
        if (q.size() == 0) begin
          check("alu_extra_step", 1, 0);
        end else begin
          e = q.pop_front();
          check("alu_op", alu_op, e.op);
          check("alu_src1", alu_src1, e.s1);
          check("alu_src2", alu_src2, e.s2);
        end
      end else begin
        check("alu_idle_drive", {alu_op, alu_src1, alu_src2}, 0);
      end
      if (done) begin
        seen = 1;
        check("done_cycle", cyc, exp_cyc);
        check("product", product, exp_p);
        check("ovf", ovf, exp_o);
        if (poke) begin start = 1'b1; mcand = 32'd3; mplier = 32'd3; end
      end else begin
        if (poke) start = (cyc == 3);
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    check("trace_len", q.size(), 0);
    @(negedge clk);
    start = 1'b0;
    check("post_busy", busy, 0);
    check("post_done", done, 0);
    check("post_product", product, exp_p);
    check("post_ovf", ovf, exp_o);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; mcand = $urandom; mplier = $urandom;
    @(negedge clk);
    mcand = $urandom; mplier = $urandom;
    @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("reset_idle_busy", busy, 0);

    run(32'd7, 32'd6, 0);
    run(32'hFFFFFFFF, 32'd0, 0);
    run(32'hFFFFFFFF, 32'd3, 0);
    run(32'h00010000, 32'h00010000, 0);
    run(32'h80000000, 32'd1, 0);
    run(32'd1, 32'hFFFFFFFF, 0);
    run(32'd9, 32'd11, 1);

    // Reset in cycle 5 of 7x6: no done, outputs cleared.
    @(negedge clk);
    start = 1'b1; mcand = 32'd7; mplier = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outputs_zero("midrst");
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_done", done, 0);
    end
    run(32'd3, 32'd5, 0);

    for (int t = 0; t < 30; t++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case (t % 3)
        0: b = b >> $urandom_range(31, 0);
        1: a = a >> $urandom_range(31, 0);
        default: ;
      endcase
      run(a, b, t[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
